exec_mask_sched: RTL and testbench

Per-core control-flow scheduler that owns the current (PC, execution mask) pair and sequences the fetch front-end. It consumes the redirect events produced after execute/store (jump, conditional jump with split masks, sequential advance, halt) and keeps a bounded divergence stack so that both sides of a divergent conditional jump are run in turn. It sits between the store stage's redirect output and the fetch stage's request input, one instance per core.

---
 rtl/exec_mask_sched_pkg.sv | 33 +++
 rtl/exec_mask_stack.sv | 69 ++++++
 rtl/exec_mask_sched.sv | 175 +++++++++++++++++
 tb/tb_exec_mask_sched.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_mask_sched_pkg.sv
// Shared types for the per-core control-flow scheduler.
//   exec_event_kind_t : redirect event encoding (NEXT/JMP/CJMP/HALT)
//   sched_state_t     : scheduler FSM states
//   sched_entry_t     : one divergence-stack entry {pc, mask}
//   execution_mask_t / ALL_THREADS_EXEC_MASK : default-width lane mask and its all-lanes value
package exec_mask_sched_pkg;

    localparam int EXEC_NUM_THREADS = 64;
    localparam int EXEC_PC_W        = 64;

    typedef logic [EXEC_NUM_THREADS-1:0] execution_mask_t;

    localparam execution_mask_t ALL_THREADS_EXEC_MASK = '1;

    typedef enum logic [1:0] {
        EV_NEXT = 2'd0,
        EV_JMP  = 2'd1,
        EV_CJMP = 2'd2,
        EV_HALT = 2'd3
    } exec_event_kind_t;

    typedef enum logic [1:0] {
        ST_ISSUE  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [EXEC_PC_W-1:0] pc;
        execution_mask_t      mask;
    } sched_entry_t;

endpackage

// File: rtl/exec_mask_stack.sv
// Divergence stack: DEPTH-entry LIFO of {pc, mask} paths waiting to run.
// Ports:
//   clk, reset            : clock, synchronous active-high reset (clears occupancy)
//   push, push_pc/mask    : store an entry; ignored when full
//   pop                   : discard top entry; ignored when empty
//   top_pc, top_mask      : most recently pushed entry (undefined when empty)
//   full, empty, depth    : occupancy
// The caller never asserts push and pop in the same cycle.
module exec_mask_stack
    import exec_mask_sched_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int PC_W        = EXEC_PC_W,
    parameter int NUM_THREADS = EXEC_NUM_THREADS,
    localparam int DW         = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [PC_W-1:0]        push_pc,
    input  logic [NUM_THREADS-1:0] push_mask,
    output logic [PC_W-1:0]        top_pc,
    output logic [NUM_THREADS-1:0] top_mask,
    output logic                   full,
    output logic                   empty,
    output logic [DW-1:0]          depth
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0]        pc_mem   [DEPTH];
    logic [NUM_THREADS-1:0] mask_mem [DEPTH];
    logic [DW-1:0]          depth_q;
    logic [AW-1:0]          wr_idx;
    logic [AW-1:0]          rd_idx;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (depth_q == DW'(DEPTH));
    assign empty   = (depth_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_idx  = AW'(depth_q);
    assign rd_idx  = AW'(depth_q - DW'(1));

    assign top_pc   = pc_mem[rd_idx];
    assign top_mask = mask_mem[rd_idx];
    assign depth    = depth_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
        end else if (do_push) begin
            depth_q <= depth_q + DW'(1);
        end else if (do_pop) begin
            depth_q <= depth_q - DW'(1);
        end
    end

    // Entry storage needs no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            pc_mem[wr_idx]   <= push_pc;
            mask_mem[wr_idx] <= push_mask;
        end
    end

endmodule

// File: rtl/exec_mask_sched.sv
// Per-core control-flow scheduler: owns the current (pc, mask) pair, issues
// one fetch per path step, applies one redirect event per fetch and keeps a
// divergence stack so both sides of a split conditional jump get run.
// Optional feature macro: EXEC_SCHED_RECONVERGE_EN -- a NEXT/JMP whose target
// equals the top stacked PC pops that entry and merges its lanes back in.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   ev_valid/ev_ready/ev_kind         : redirect event handshake and kind
//   ev_pc_a/ev_pc_b/ev_mask_a/ev_mask_b : event targets and CJMP lane split
//   fetch_valid/fetch_ready           : fetch request handshake
//   fetch_pc/fetch_mask               : request contents (current path)
//   halted                            : every path finished
//   overflow                          : sticky, a push was dropped on a full stack
//   stack_depth                       : occupied divergence-stack entries
//
// state     | meaning
// ST_ISSUE  | presenting current path to fetch, waiting for fetch_ready
// ST_WAIT   | fetch issued, waiting for its redirect event
// ST_HALTED | all paths done; only reset leaves
module exec_mask_sched
    import exec_mask_sched_pkg::*;
#(
    parameter int              NUM_THREADS = EXEC_NUM_THREADS,
    parameter int              PC_W        = EXEC_PC_W,
    parameter int              DEPTH       = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    localparam int             SDW         = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ev_valid,
    output logic                   ev_ready,
    input  logic [1:0]             ev_kind,
    input  logic [PC_W-1:0]        ev_pc_a,
    input  logic [PC_W-1:0]        ev_pc_b,
    input  logic [NUM_THREADS-1:0] ev_mask_a,
    input  logic [NUM_THREADS-1:0] ev_mask_b,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [PC_W-1:0]        fetch_pc,
    output logic [NUM_THREADS-1:0] fetch_mask,
    output logic                   halted,
    output logic                   overflow,
    output logic [SDW-1:0]         stack_depth
);

    sched_state_t           state_q, state_d;
    logic [PC_W-1:0]        cur_pc, pc_d;
    logic [NUM_THREADS-1:0] cur_mask, mask_d;
    logic                   overflow_q, ovf_set;
    logic                   push, pop;
    logic [PC_W-1:0]        top_pc;
    logic [NUM_THREADS-1:0] top_mask;
    logic                   full, empty;
    exec_event_kind_t       kind;
    logic                   a_live, b_live, end_path;

    exec_mask_stack #(
        .DEPTH      (DEPTH),
        .PC_W       (PC_W),
        .NUM_THREADS(NUM_THREADS)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_pc  (ev_pc_b),
        .push_mask(ev_mask_b),
        .top_pc   (top_pc),
        .top_mask (top_mask),
        .full     (full),
        .empty    (empty),
        .depth    (stack_depth)
    );

    assign kind   = exec_event_kind_t'(ev_kind);
    assign a_live = |ev_mask_a;
    assign b_live = |ev_mask_b;

    always_comb begin
        state_d     = state_q;
        pc_d        = cur_pc;
        mask_d      = cur_mask;
        push        = 1'b0;
        pop         = 1'b0;
        ovf_set     = 1'b0;
        end_path    = 1'b0;
        fetch_valid = 1'b0;
        ev_ready    = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_ISSUE: begin
                fetch_valid = 1'b1;
                if (fetch_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                ev_ready = 1'b1;
                if (ev_valid) begin
                    state_d = ST_ISSUE;
                    case (kind)
                        EV_NEXT, EV_JMP: begin
                            pc_d = ev_pc_a;
`ifdef EXEC_SCHED_RECONVERGE_EN
                            if (!empty && ev_pc_a == top_pc) begin
                                pop    = 1'b1;
                                mask_d = cur_mask | top_mask;
                            end
`endif
                        end
                        EV_CJMP: begin
                            if (a_live && b_live) begin
                                push    = !full;
                                ovf_set = full;
                                pc_d    = ev_pc_a;
                                mask_d  = ev_mask_a;
                            end else if (b_live) begin
                                pc_d   = ev_pc_b;
                                mask_d = ev_mask_b;
                            end else if (a_live) begin
                                pc_d   = ev_pc_a;
                                mask_d = ev_mask_a;
                            end else begin
                                end_path = 1'b1;
                            end
                        end
                        default: end_path = 1'b1;
                    endcase
                    // Finished path: resume the most recent deferred one, or stop.
                    if (end_path) begin
                        if (!empty) begin
                            pop    = 1'b1;
                            pc_d   = top_pc;
                            mask_d = top_mask;
                        end else begin
                            state_d = ST_HALTED;
                        end
                    end
                end
            end
            ST_HALTED: halted = 1'b1;
            default: state_d = ST_ISSUE;
        endcase

        // Handshake outputs are quiet during the reset cycle whatever the old state.
        if (reset) begin
            fetch_valid = 1'b0;
            ev_ready    = 1'b0;
            halted      = 1'b0;
            push        = 1'b0;
            pop         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ISSUE;
            cur_pc     <= RESET_PC;
            cur_mask   <= '1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_pc     <= pc_d;
            cur_mask   <= mask_d;
            overflow_q <= overflow_q | ovf_set;
        end
    end

    assign fetch_pc   = cur_pc;
    assign fetch_mask = cur_mask;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_exec_mask_sched.sv
module tb_exec_mask_sched;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ev_valid = 1'b0;
    logic        ev_ready;
    logic [1:0]  ev_kind = 2'd0;
    logic [63:0] ev_pc_a = '0, ev_pc_b = '0;
    logic [63:0] ev_mask_a = '0, ev_mask_b = '0;
    logic        fetch_valid;
    logic        fetch_ready = 1'b0;
    logic [63:0] fetch_pc, fetch_mask;
    logic        halted, overflow;
    logic [1:0]  stack_depth;

    int checks = 0;
    int errors = 0;

    exec_mask_sched #(
        .NUM_THREADS(64),
        .PC_W       (64),
        .DEPTH      (2),
        .RESET_PC   (64'h100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_kind    (ev_kind),
        .ev_pc_a    (ev_pc_a),
        .ev_pc_b    (ev_pc_b),
        .ev_mask_a  (ev_mask_a),
        .ev_mask_b  (ev_mask_b),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .fetch_pc   (fetch_pc),
        .fetch_mask (fetch_mask),
        .halted     (halted),
        .overflow   (overflow),
        .stack_depth(stack_depth)
    );

    always #5 clk = ~clk;

    // Wait (bounded) for a fetch request, report it and accept it.
    task automatic take_fetch(output logic ok, output logic [63:0] pc, output logic [63:0] mask);
        ok = 1'b0;
        pc = '0;
        mask = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (fetch_valid === 1'b1) begin
                pc = fetch_pc;
                mask = fetch_mask;
                ok = 1'b1;
                fetch_ready = 1'b1;
            end
        end
        if (ok) begin
            @(negedge clk);
            fetch_ready = 1'b0;
        end
    endtask

    // Present one event as soon as the scheduler is ready; returns one cycle after acceptance.
    task automatic send_event(input logic [1:0] k, input logic [63:0] pa, input logic [63:0] ma,
                              input logic [63:0] pb, input logic [63:0] mb, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (ev_ready === 1'b1) begin
                ev_valid = 1'b1;
                ev_kind = k;
                ev_pc_a = pa;
                ev_mask_a = ma;
                ev_pc_b = pb;
                ev_mask_b = mb;
                ok = 1'b1;
            end
        end
        if (ok) begin
            @(negedge clk);
            ev_valid = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        ev_valid = 1'b0;
        fetch_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic ok;
        logic [63:0] pc, mask;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (fetch_valid !== 1'b0 || ev_ready !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: fv=%b er=%b h=%b expected 0 0 0", fetch_valid, ev_ready, halted);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_valid !== 1'b1 || stack_depth !== 2'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_fetch: fv=%b depth=%0d ovf=%b expected 1 0 0", fetch_valid, stack_depth, overflow);
        end
        take_fetch(ok, pc, mask);
        checks++;
        if (!ok || pc !== 64'h100 || mask !== ONES) begin
            errors++;
            $display("FAIL reset_pc: ok=%b pc=%h mask=%h expected pc 100 mask all ones", ok, pc, mask);
        end
    endtask

    task automatic test_next();
        logic ok;
        logic [63:0] pc, mask;
        send_event(2'd0, 64'h108, '0, '0, '0, ok);
        checks++;
        if (!ok || fetch_valid !== 1'b1 || fetch_pc !== 64'h108 || fetch_mask !== ONES) begin
            errors++;
            $display("FAIL next_latency: ok=%b fv=%b pc=%h mask=%h expected 1 108 all ones", ok, fetch_valid, fetch_pc, fetch_mask);
        end
        take_fetch(ok, pc, mask);
    endtask

    task automatic test_cjmp_split();
        logic ok;
        logic [63:0] pc, mask;
        send_event(2'd2, 64'h200, 64'h0F, 64'h108, 64'hF0, ok);
        take_fetch(ok, pc, mask);
        checks++;
        if (!ok || pc !== 64'h200 || mask !== 64'h0F || stack_depth !== 2'd1) begin
            errors++;
            $display("FAIL cjmp_taken: pc=%h mask=%h depth=%0d expected 200 0f 1", pc, mask, stack_depth);
        end
        send_event(2'd3, '0, '0, '0, '0, ok);
        checks++;
        if (!ok || fetch_valid !== 1'b1 || fetch_pc !== 64'h108 || fetch_mask !== 64'hF0 || stack_depth !== 2'd0) begin
            errors++;
            $display("FAIL halt_pop: fv=%b pc=%h mask=%h depth=%0d expected 1 108 f0 0", fetch_valid, fetch_pc, fetch_mask, stack_depth);
        end
        take_fetch(ok, pc, mask);
        send_event(2'd3, '0, '0, '0, '0, ok);
        checks++;
        if (!ok || halted !== 1'b1 || fetch_valid !== 1'b0 || ev_ready !== 1'b0) begin
            errors++;
            $display("FAIL halt_final: h=%b fv=%b er=%b expected 1 0 0", halted, fetch_valid, ev_ready);
        end
    endtask

    task automatic test_cjmp_one_side();
        logic ok;
        logic [63:0] pc, mask;
        apply_reset();
        take_fetch(ok, pc, mask);
        send_event(2'd2, 64'h999, 64'h0, 64'h400, 64'hFF, ok);
        take_fetch(ok, pc, mask);
        checks++;
        if (!ok || pc !== 64'h400 || mask !== 64'hFF || stack_depth !== 2'd0) begin
            errors++;
            $display("FAIL cjmp_mask_a_zero: pc=%h mask=%h depth=%0d expected 400 ff 0", pc, mask, stack_depth);
        end
        send_event(2'd2, 64'h500, 64'h0F, 64'h777, 64'h0, ok);
        take_fetch(ok, pc, mask);
        checks++;
        if (!ok || pc !== 64'h500 || mask !== 64'h0F || stack_depth !== 2'd0) begin
            errors++;
            $display("FAIL cjmp_mask_b_zero: pc=%h mask=%h depth=%0d expected 500 0f 0", pc, mask, stack_depth);
        end
        send_event(2'd2, 64'h600, 64'h0, 64'h700, 64'h0, ok);
        checks++;
        if (!ok || halted !== 1'b1) begin
            errors++;
            $display("FAIL cjmp_both_zero: halted=%b expected 1", halted);
        end
    endtask

    task automatic test_overflow();
        logic ok;
        logic [63:0] pc, mask;
        apply_reset();
        take_fetch(ok, pc, mask);
        send_event(2'd2, 64'h10, 64'h1, 64'h20, 64'h2, ok);
        take_fetch(ok, pc, mask);
        send_event(2'd2, 64'h30, 64'h1, 64'h40, 64'h2, ok);
        take_fetch(ok, pc, mask);
        checks++;
        if (stack_depth !== 2'd2 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL stack_fill: depth=%0d ovf=%b expected 2 0", stack_depth, overflow);
        end
        send_event(2'd2, 64'h50, 64'h1, 64'h60, 64'h2, ok);
        take_fetch(ok, pc, mask);
        checks++;
        if (!ok || overflow !== 1'b1 || stack_depth !== 2'd2 || pc !== 64'h50 || mask !== 64'h1) begin
            errors++;
            $display("FAIL overflow: ovf=%b depth=%0d pc=%h mask=%h expected 1 2 50 1", overflow, stack_depth, pc, mask);
        end
        send_event(2'd3, '0, '0, '0, '0, ok);
        take_fetch(ok, pc, mask);
        checks++;
        if (!ok || pc !== 64'h40 || mask !== 64'h2 || stack_depth !== 2'd1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_pop: pc=%h mask=%h depth=%0d ovf=%b expected 40 2 1 1", pc, mask, stack_depth, overflow);
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        logic [63:0] pc, mask;
        @(negedge clk);
        ev_valid = 1'b1;
        ev_kind = 2'd3;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (stack_depth !== 2'd0 || overflow !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_clear: depth=%0d ovf=%b fv=%b expected 0 0 0", stack_depth, overflow, fetch_valid);
        end
        ev_valid = 1'b0;
        reset = 1'b0;
        take_fetch(ok, pc, mask);
        checks++;
        if (!ok || pc !== 64'h100 || mask !== ONES || stack_depth !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_restart: pc=%h mask=%h depth=%0d expected 100 all ones 0", pc, mask, stack_depth);
        end
    endtask

    task automatic test_stall();
        logic ok;
        logic [63:0] pc, mask;
        send_event(2'd1, 64'h800, '0, '0, '0, ok);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (fetch_valid !== 1'b1 || fetch_pc !== 64'h800 || fetch_mask !== ONES || ev_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: fv=%b pc=%h mask=%h er=%b expected 1 800 all ones 0", i, fetch_valid, fetch_pc, fetch_mask, ev_ready);
            end
            ev_valid = (i == 2);
            ev_kind = 2'd1;
            ev_pc_a = 64'hBAD;
        end
        ev_valid = 1'b0;
        take_fetch(ok, pc, mask);
        checks++;
        if (!ok || pc !== 64'h800) begin
            errors++;
            $display("FAIL stall_accept: pc=%h expected 800", pc);
        end
        send_event(2'd0, 64'h808, '0, '0, '0, ok);
        take_fetch(ok, pc, mask);
        checks++;
        if (!ok || pc !== 64'h808 || mask !== ONES) begin
            errors++;
            $display("FAIL stall_ignored_event: pc=%h mask=%h expected 808 all ones", pc, mask);
        end
    endtask

    task automatic test_reconverge();
        logic ok;
        logic [63:0] pc, mask;
        apply_reset();
        take_fetch(ok, pc, mask);
        send_event(2'd2, 64'h200, 64'h0F, 64'h300, 64'hF0, ok);
        take_fetch(ok, pc, mask);
        send_event(2'd1, 64'h300, '0, '0, '0, ok);
        take_fetch(ok, pc, mask);
        checks++;
`ifdef EXEC_SCHED_RECONVERGE_EN
        if (!ok || pc !== 64'h300 || mask !== 64'hFF || stack_depth !== 2'd0) begin
            errors++;
            $display("FAIL reconverge: pc=%h mask=%h depth=%0d expected 300 ff 0", pc, mask, stack_depth);
        end
`else
        if (!ok || pc !== 64'h300 || mask !== 64'h0F || stack_depth !== 2'd1) begin
            errors++;
            $display("FAIL no_reconverge: pc=%h mask=%h depth=%0d expected 300 0f 1", pc, mask, stack_depth);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_next();
        test_stall();
        test_cjmp_split();
        test_cjmp_one_side();
        test_overflow();
        test_reset_mid();
        test_reconverge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
